unary_expander32: RTL
=====================

# unary_expander32

Count-to-unary expander: the decode-side counterpart of the 32-input population counter. Accepts a 6-bit ones-count over a valid/ready handshake and regenerates a 32-bit word holding exactly that many ones, either as one parallel thermometer word or as a 32-beat serial bitstream. Sits downstream of the popcount stage in the AQFP/ISCAS benchmark suite as its round-trip check.

## Interface
- WIDTH, 32, output word width and serial beat count
- CW, 6, count width; must satisfy 2^CW > WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  count beat valid
- in_ready  output  1  block can accept a count this cycle
- in_count  input  CW  requested number of ones
- in_mode  input  1  0 = parallel thermometer, 1 = serial bitstream
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts the beat
- out_word  output  WIDTH  parallel: thermometer word; serial: bit 0 carries the stream, bits [WIDTH-1:1] = 0
- out_last  output  1  final beat of the current count
- out_err  output  1  in_count exceeded WIDTH and was saturated

## Operation
- States: IDLE, PAR, SER.
- IDLE: in_ready = 1. On in_valid, latch k = min(in_count, WIDTH) and err = (in_count > WIDTH). Go to PAR or SER per in_mode.
- PAR: one beat. out_word = (1<<k)-1, i.e. bits [k-1:0] set; k = 0 gives all zeros and k = 32 gives all ones. out_last = 1.
- SER: WIDTH beats indexed b = 0..WIDTH-1. out_word[0] = (b < k). out_last = 1 only at b = WIDTH-1. b advances only on out_valid & out_ready.
- out_err is held constant on every beat of the transaction.
- The transaction ends on out_valid & out_ready & out_last. In that same cycle, in_ready = 1, so a new count is accepted back-to-back and the block re-enters PAR or SER. Otherwise it returns to IDLE.
- in_ready = (state == IDLE) | (out_valid & out_ready & out_last). in_ready is combinational from out_ready.
- in_count and in_mode are ignored while in_ready = 0.
- Serial stream property: the number of ones over WIDTH beats equals k.

## Timing
- Reset values: state IDLE, out_valid 0, out_word 0, out_last 0, out_err 0, beat index 0, in_ready 1.
- Latency: a count accepted in cycle t gives out_valid = 1 in cycle t+1. There is no combinational path from in_* to out_*.
- Throughput: parallel mode, one count per cycle while out_ready is held high. Serial mode, one count per WIDTH cycles.
- Backpressure: while out_valid & !out_ready, out_word, out_last and out_err hold stable and the beat index does not advance.
- rst asserted mid-transaction aborts it. The next cycle shows the reset values, and no partial beat is replayed.
- Simultaneous final-beat acceptance and new in_valid: the new beat appears in the following cycle with no bubble.

## Structure
- Shared package unary_pkg holds:
  - WIDTH and CW defaults
  - state enum {IDLE, PAR, SER}
  - mode constants MODE_PAR = 0, MODE_SER = 1
  - saturation helper function
- Sub-module thermo_decode: purely combinational, CW-bit k to WIDTH-bit thermometer. Used for the PAR word. The SER bit uses the comparator (b < k).
- Top: FSM, k/err/mode registers, a 5-bit beat counter, and the output registers.

## Test plan
- Parallel sweep: in_mode 0, in_count 0..32 back-to-back with out_ready = 1. Expected: out_word = (1<<k)-1 each cycle (0x00000000 for 0, 0x0000001F for 5, 0xFFFFFFFF for 32), out_last = 1, one result per cycle, in_ready stays 1.
- Saturation: in_count 45 in mode 0. Expected: out_word 0xFFFFFFFF, out_err 1. The next count 3 gives 0x00000007 with out_err 0.
- Serial: in_mode 1, in_count 7. Expected: 32 beats, out_word[0] = 1 on beats 0..6 and 0 on beats 7..31, out_last only on beat 31. in_ready = 1 only during the beat-31 handshake.
- Backpressure: serial count 10 with out_ready toggled randomly. Expected: the beat sequence is identical to the unstalled case and outputs are stable while stalled. Also apply a parallel count 32 stalled 5 cycles: out_word holds 0xFFFFFFFF throughout.
- Reset mid-serial: assert rst at beat 12 of count 20. Expected: the next cycle has out_valid 0 and in_ready 1. A following serial count 2 produces a fresh stream from beat 0.
- Round trip: feed random 32-bit vectors through a popcount reference model, then through this block in both modes. Expected: the popcount of the regenerated word or stream equals the original count.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared definitions for the count-to-unary expander: default sizes, FSM
// state encoding, mode constants and the count saturation helpers.
package unary_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CW    = 6;
    localparam int BEAT_W    = $clog2(DEF_WIDTH);

    // Largest legal count, expressed in count-width bits.
    localparam logic [DEF_CW-1:0] WIDTH_CNT = DEF_CW'(DEF_WIDTH);

    // Index of the final serial beat.
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DEF_WIDTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAR  = 2'd1,
        SER  = 2'd2
    } state_e;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SER = 1'b1;

    // Clamp a requested count to the word width.
    function automatic logic [DEF_CW-1:0] sat_count(input logic [DEF_CW-1:0] cnt);
        if (cnt > WIDTH_CNT) begin
            return WIDTH_CNT;
        end else begin
            return cnt;
        end
    endfunction

    // Flags a request that had to be clamped.
    function automatic logic count_over(input logic [DEF_CW-1:0] cnt);
        return (cnt > WIDTH_CNT);
    endfunction

endpackage

// File: rtl/unary_expander32_checker.sv
// Handshake invariants of the expander, kept apart from the datapath.
module unary_expander32_checker
    import unary_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    input logic                 in_ready,
    input logic                 out_valid,
    input logic                 out_ready,
    input logic [DEF_WIDTH-1:0] out_word,
    input logic                 out_last,
    input logic                 out_err
);

    // A stalled beat must be presented again unchanged.
    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_word) && $stable(out_last) && $stable(out_err)))
        else $error("stalled beat changed");

    // With nothing in flight the block must accept.
    a_ready_when_idle: assert property (@(posedge clk) disable iff (rst)
        !out_valid |-> in_ready)
        else $error("in_ready low while idle");

    // Completing a transaction opens the input in the same cycle.
    a_ready_on_last: assert property (@(posedge clk) disable iff (rst)
        (out_valid && out_ready && out_last) |-> in_ready)
        else $error("in_ready low on final handshake");

    // Mid-transaction the input stays closed.
    a_busy_blocks: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_last) |-> !in_ready)
        else $error("in_ready high mid-transaction");

endmodule

// File: rtl/unary_expander32_thermo_decode.sv
// Purely combinational count-to-thermometer decoder: bits [k-1:0] set.
module thermo_decode
    import unary_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic [CW-1:0]    k,
    output logic [WIDTH-1:0] therm
);

    // Each bit is set exactly when its index lies below the count.
    always_comb begin
        therm = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) < k) begin
                therm[i] = 1'b1;
            end else begin
                therm[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/unary_expander32.sv
// Count-to-unary expander: turns an accepted ones-count into either one
// thermometer word or a 32-beat serial stream carrying that many ones.
module unary_expander32
    import unary_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DEF_CW-1:0]    in_count,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DEF_WIDTH-1:0] out_word,
    output logic                 out_last,
    output logic                 out_err
);

    state_e               state_r;
    state_e               state_n_s;
    logic [DEF_CW-1:0]    k_r;
    logic [DEF_CW-1:0]    k_n_s;
    logic                 err_r;
    logic                 err_n_s;
    logic [BEAT_W-1:0]    beat_r;
    logic [BEAT_W-1:0]    beat_n_s;

    logic                 out_valid_r;
    logic                 out_valid_n_s;
    logic [DEF_WIDTH-1:0] out_word_r;
    logic [DEF_WIDTH-1:0] out_word_n_s;
    logic                 out_last_r;
    logic                 out_last_n_s;
    logic                 out_err_r;
    logic                 out_err_n_s;

    logic [DEF_WIDTH-1:0] therm_s;
    logic                 ser_bit_s;
    logic                 adv_s;
    logic                 fire_s;
    logic                 accept_s;

    // Handshake qualifiers: a beat moves, the final beat moves, a count enters.
    assign adv_s    = out_valid_r & out_ready;
    assign fire_s   = adv_s & out_last_r;
    assign in_ready = (state_r == IDLE) | fire_s;
    assign accept_s = in_valid & in_ready;

    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_last  = out_last_r;
    assign out_err   = out_err_r;

    // The thermometer is decoded from the next count so the word is registered.
    thermo_decode #(
        .WIDTH (DEF_WIDTH),
        .CW    (DEF_CW)
    ) u_thermo (
        .k     (k_n_s),
        .therm (therm_s)
    );

    // Serial bit for the upcoming beat: one while the beat index is below k.
    assign ser_bit_s = ({{(DEF_CW - BEAT_W){1'b0}}, beat_n_s} < k_n_s);

    // Next-state logic: accept a count, finish, step the serial beat, or hold.
    always_comb begin
        state_n_s = state_r;
        k_n_s     = k_r;
        err_n_s   = err_r;
        beat_n_s  = beat_r;
        if (accept_s) begin
            k_n_s    = sat_count(in_count);
            err_n_s  = count_over(in_count);
            beat_n_s = BEAT_ZERO;
            if (in_mode == MODE_SER) begin
                state_n_s = SER;
            end else begin
                state_n_s = PAR;
            end
        end else if (fire_s) begin
            state_n_s = IDLE;
            beat_n_s  = BEAT_ZERO;
        end else if (adv_s && (state_r == SER)) begin
            beat_n_s = beat_r + BEAT_ONE;
        end else begin
            state_n_s = state_r;
        end
    end

    // Output beat for the next cycle, derived from the next state only.
    always_comb begin
        out_valid_n_s = 1'b0;
        out_word_n_s  = {DEF_WIDTH{1'b0}};
        out_last_n_s  = 1'b0;
        out_err_n_s   = 1'b0;
        case (state_n_s)
            PAR: begin
                out_valid_n_s = 1'b1;
                out_word_n_s  = therm_s;
                out_last_n_s  = 1'b1;
                out_err_n_s   = err_n_s;
            end
            SER: begin
                out_valid_n_s = 1'b1;
                out_word_n_s  = {{(DEF_WIDTH - 1){1'b0}}, ser_bit_s};
                out_last_n_s  = (beat_n_s == LAST_BEAT);
                out_err_n_s   = err_n_s;
            end
            IDLE: begin
                out_valid_n_s = 1'b0;
            end
            default: begin
                out_valid_n_s = 1'b0;
            end
        endcase
    end

    // State, transaction and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            k_r         <= {DEF_CW{1'b0}};
            err_r       <= 1'b0;
            beat_r      <= BEAT_ZERO;
            out_valid_r <= 1'b0;
            out_word_r  <= {DEF_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            k_r         <= k_n_s;
            err_r       <= err_n_s;
            beat_r      <= beat_n_s;
            out_valid_r <= out_valid_n_s;
            out_word_r  <= out_word_n_s;
            out_last_r  <= out_last_n_s;
            out_err_r   <= out_err_n_s;
        end
    end

endmodule
